bus_compare_sampler: RTL

Sampling and comparison stage fed by the clock divider's `clkPls` strobe. On each rising edge of `clkPls` it captures two parallel buses, compares them bit by bit, and tracks consecutive mismatches. It raises a sticky alarm when the mismatch run reaches a limit and keeps a saturating total error count. Its outputs feed the status/reporting logic of the bus comparator.

---
 rtl/bus_cmp_pkg.sv | 16 +
 rtl/bus_compare_sampler_edge_detect_rise.sv | 27 ++
 rtl/bus_compare_sampler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bus_cmp_pkg.sv
// Shared types and constants for the bus compare sampler.
// Imported by the sampler top and its helpers.
package bus_cmp_pkg;

    localparam int unsigned DEF_WIDTH          = 8;
    localparam int unsigned DEF_MISMATCH_LIMIT = 3;
    localparam int unsigned DEF_CNT_WIDTH      = 16;
    localparam int unsigned RUN_W              = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_UPDATE  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_compare_sampler_edge_detect_rise.sv
// Rising-edge detector: one delayed copy of the input.
// Reusable for any divider strobe output.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/bus_compare_sampler.sv
// Captures two buses on each clkPls rising edge, compares them and
// tracks mismatch runs, a sticky alarm and a saturating error count.
module bus_compare_sampler
    import bus_cmp_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned MISMATCH_LIMIT = DEF_MISMATCH_LIMIT,
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkPls,
    input  logic [WIDTH-1:0]     busA,
    input  logic [WIDTH-1:0]     busB,
    input  logic                 clearAlarm,
    output logic                 sampleValid,
    output logic [WIDTH-1:0]     diffMask,
    output logic                 mismatch,
    output logic [RUN_W-1:0]     runLen,
    output logic                 alarm,
    output logic [CNT_WIDTH-1:0] errCount
);

    localparam logic [RUN_W-1:0] LIMIT = RUN_W'(MISMATCH_LIMIT);

    logic plsEdge;

    state_e               state_d,    state_q;
    logic [WIDTH-1:0]     capA_d,     capA_q;
    logic [WIDTH-1:0]     capB_d,     capB_q;
    logic [WIDTH-1:0]     diffMask_d, diffMask_q;
    logic                 mismatch_d, mismatch_q;
    logic [RUN_W-1:0]     runLen_d,   runLen_q;
    logic                 alarm_d,    alarm_q;
    logic [CNT_WIDTH-1:0] errCount_d, errCount_q;

    logic [RUN_W-1:0]     run_next;

    edge_detect_rise u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (clkPls),
        .rise (plsEdge)
    );

    // Saturating run length; LIMIT is at most 15 so no wrap inside RUN_W.
    assign run_next = (runLen_q >= LIMIT) ? LIMIT : runLen_q + RUN_W'(1);

    always_comb begin
        state_d    = state_q;
        capA_d     = capA_q;
        capB_d     = capB_q;
        diffMask_d = diffMask_q;
        mismatch_d = mismatch_q;
        runLen_d   = runLen_q;
        errCount_d = errCount_q;
        alarm_d    = clearAlarm ? 1'b0 : alarm_q;

        unique case (state_q)
            ST_IDLE: begin
                if (plsEdge) begin
                    capA_d  = busA;
                    capB_d  = busB;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                diffMask_d = capA_q ^ capB_q;
                state_d    = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (diffMask_q != '0) begin
                    mismatch_d = 1'b1;
                    runLen_d   = run_next;
                    if (!(&errCount_q)) begin
                        errCount_d = errCount_q + CNT_WIDTH'(1);
                    end
                    // A set in this cycle overrides a concurrent clear.
                    if (run_next == LIMIT) begin
                        alarm_d = 1'b1;
                    end
                end else begin
                    mismatch_d = 1'b0;
                    runLen_d   = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            capA_q     <= '0;
            capB_q     <= '0;
            diffMask_q <= '0;
            mismatch_q <= 1'b0;
            runLen_q   <= '0;
            alarm_q    <= 1'b0;
            errCount_q <= '0;
        end else begin
            state_q    <= state_d;
            capA_q     <= capA_d;
            capB_q     <= capB_d;
            diffMask_q <= diffMask_d;
            mismatch_q <= mismatch_d;
            runLen_q   <= runLen_d;
            alarm_q    <= alarm_d;
            errCount_q <= errCount_d;
        end
    end

    assign sampleValid = (state_q == ST_UPDATE);
    assign diffMask    = diffMask_q;
    assign mismatch    = mismatch_q;
    assign runLen      = runLen_q;
    assign alarm       = alarm_q;
    assign errCount    = errCount_q;

endmodule
